// File: rtl/serial_to_parallel_sync_pkg.sv
// Shared definitions for the serial link byte aligner and its transmitter-side peers.
package serial_to_parallel_sync_pkg;

    // Alignment / idle symbol, common with the parallel-to-serial transmitter.
    localparam logic [7:0] COMMA_BC = 8'hBC;

    // Default byte width and default length of the comma run needed to go active.
    localparam int WIDTH_DEF    = 8;
    localparam int BC_COUNT_DEF = 4;

    // Alignment FSM states.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } sync_state_e;

endpackage

// File: rtl/serial_to_parallel_sync_comma_detect.sv
// Combinational comparator flagging a candidate word equal to the comma symbol.
module serial_to_parallel_sync_comma_detect
    import serial_to_parallel_sync_pkg::*;
#(
    parameter int               WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] COMMA = COMMA_BC
) (
    input  logic [WIDTH-1:0] word,
    output logic             is_comma
);

    // Pure equality compare; no state so it can be shared with the transmitter checker.
    assign is_comma = (word == COMMA);

endmodule

// File: rtl/serial_to_parallel_sync.sv
// Serial-to-parallel converter with comma-based byte alignment.
// Hunts bit-by-bit for the comma, confirms alignment over a run of commas at
// byte boundaries, then delivers each non-comma byte held for a full byte period.
module serial_to_parallel_sync
    import serial_to_parallel_sync_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] COMMA    = COMMA_BC,
    parameter int               BC_COUNT = BC_COUNT_DEF
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int BITW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BCW  = $clog2(BC_COUNT + 1);

    // Only the low WIDTH-1 history bits ever feed the candidate word, so the
    // oldest bit of the conceptual shift register is not stored.
    logic [WIDTH-2:0]  shift_r;
    logic [BITW-1:0]   bit_cnt_r;
    logic [BCW-1:0]    bc_cnt_r;
    sync_state_e       state_r;
    logic [WIDTH-1:0]  data_r;
    logic              valid_r;
    logic              active_r;

    logic [WIDTH-1:0]  word_s;
    logic              is_comma_s;
    logic              boundary_s;
    logic              run_done_s;

    // Saturating increment of the comma-run counter.
    function automatic logic [BCW-1:0] bc_inc(input logic [BCW-1:0] cnt);
        logic [BCW-1:0] res;
        if (int'(cnt) >= BC_COUNT) begin
            res = cnt;
        end else begin
            res = cnt + BCW'(1);
        end
        return res;
    endfunction

    assign word_s     = {shift_r, data_in};
    assign boundary_s = (bit_cnt_r == BITW'(WIDTH - 1));
    assign run_done_s = ((int'(bc_cnt_r) + 1) == BC_COUNT);

    serial_to_parallel_sync_comma_detect #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_comma_detect (
        .word     (word_s),
        .is_comma (is_comma_s)
    );

    // Shift register, bit/comma counters, alignment FSM and registered outputs.
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
            bc_cnt_r  <= '0;
            state_r   <= HUNT;
            data_r    <= '0;
            valid_r   <= 1'b0;
            active_r  <= 1'b0;
        end else begin
            shift_r <= word_s[WIDTH-2:0];
            case (state_r)
                HUNT: begin
                    if (is_comma_s) begin
                        bit_cnt_r <= '0;
                        bc_cnt_r  <= BCW'(1);
                        state_r   <= ALIGN;
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                        bc_cnt_r  <= bc_cnt_r;
                        state_r   <= HUNT;
                    end
                end
                ALIGN: begin
                    if (boundary_s) begin
                        bit_cnt_r <= '0;
                        if (is_comma_s) begin
                            bc_cnt_r <= bc_inc(bc_cnt_r);
                            if (run_done_s) begin
                                state_r  <= ACTIVE;
                                active_r <= 1'b1;
                            end else begin
                                state_r  <= ALIGN;
                            end
                        end else begin
                            // Run broken: resume the bit-level search on the next edge.
                            bc_cnt_r <= '0;
                            state_r  <= HUNT;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BITW'(1);
                    end
                end
                ACTIVE: begin
                    if (boundary_s) begin
                        bit_cnt_r <= '0;
                        if (is_comma_s) begin
                            // Idle symbol: drop valid, keep the last payload on the bus.
                            valid_r <= 1'b0;
                        end else begin
                            data_r  <= word_s;
                            valid_r <= 1'b1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BITW'(1);
                    end
                end
                default: begin
                    bit_cnt_r <= '0;
                    bc_cnt_r  <= '0;
                    state_r   <= HUNT;
                    data_r    <= '0;
                    valid_r   <= 1'b0;
                    active_r  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_r;
    assign valid_out = valid_r;
    assign active    = active_r;

endmodule

// File: tb/tb_serial_to_parallel_sync.sv
// Scoreboard bench for serial_to_parallel_sync: the stimulus pushes the expected
// {active, valid_out, data_out} after every driven edge, the monitor pops and compares.
module tb_serial_to_parallel_sync;

    logic       clk_32f;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    typedef struct packed {
        logic       act;
        logic       vld;
        logic [7:0] dat;
    } exp_t;

    exp_t exp_q[$];

    logic       cur_act;
    logic       cur_vld;
    logic [7:0] cur_dat;

    int n_cmp;
    int n_fail;

    serial_to_parallel_sync #(
        .WIDTH    (8),
        .COMMA    (8'hBC),
        .BC_COUNT (4)
    ) dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    // Drive one bit ahead of the next rising edge and record the outputs expected after it.
    task automatic drive_bit(input logic b, input logic rst);
        exp_t e;
        @(negedge clk_32f);
        data_in = b;
        reset_L = rst;
        e = {cur_act, cur_vld, cur_dat};
        exp_q.push_back(e);
    endtask

    // Send a byte MSB first; when upd is set the outputs change on its last bit.
    task automatic send_byte(input logic [7:0] b, input logic upd,
                             input logic na, input logic nv, input logic [7:0] nd);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && upd) begin
                cur_act = na;
                cur_vld = nv;
                cur_dat = nd;
            end
            drive_bit(b[i], 1'b1);
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_32f);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (active !== e.act || valid_out !== e.vld || data_out !== e.dat) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got active=%b valid=%b data=%02h, expected active=%b valid=%b data=%02h",
                             $time, active, valid_out, data_out, e.act, e.vld, e.dat);
                end
            end
        end
    end

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        reset_L = 1'b0;
        data_in = 1'b0;
        cur_act = 1'b0;
        cur_vld = 1'b0;
        cur_dat = 8'h00;

        // Reset held for 3 edges with random data.
        for (int i = 0; i < 3; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);

        // Lock with a 3-bit offset: garbage 101 then 4 commas; active on bit 35.
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
        send_byte(8'hBC, 1'b1, 1'b1, 1'b0, 8'h00);

        // Payload, idle, payload, idle.
        send_byte(8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5);
        send_byte(8'hBC, 1'b1, 1'b1, 1'b0, 8'hA5);
        send_byte(8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C);
        send_byte(8'hBC, 1'b1, 1'b1, 1'b0, 8'h3C);

        // Reset halfway through 0x5A: first nibble 0101, reset on the next edge.
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        cur_act = 1'b0;
        cur_vld = 1'b0;
        cur_dat = 8'h00;
        drive_bit(1'b1, 1'b0);

        // Broken comma run: 3 commas then 0x00, no activation.
        for (int i = 0; i < 3; i++) send_byte(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
        send_byte(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

        // Single comma window followed by a non-comma byte: ALIGN then back to HUNT.
        send_byte(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
        send_byte(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

        // Relock needs a full run of 4 commas again.
        for (int i = 0; i < 3; i++) send_byte(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
        send_byte(8'hBC, 1'b1, 1'b1, 1'b0, 8'h00);
        send_byte(8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A);
        send_byte(8'hBC, 1'b1, 1'b1, 1'b0, 8'h5A);

        // Let the monitor drain, then confirm nothing was left unchecked.
        repeat (3) @(negedge clk_32f);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
